// File: rtl/shared_delay_pkg.sv
// Types, defaults and helpers shared by the divided-clock scheduler and its arbiter.
package shared_delay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 16;
  localparam int TW_DEF   = 8;

  // Owner index width; never zero so a 1-requester build still has a legal vector.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping at NREQ.
// Zero latency, no state; the caller owns the pointer.
module rr_arbiter
  import shared_delay_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        idx_o    = IW'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_delay_scheduler.sv
// One prescaler shared by NREQ requesters: grant 1 cycle after req, burst of 2*mc*tk cycles, done pulse.
// No backpressure; a requester drops req during its burst to abort it.
module shared_delay_scheduler
  import shared_delay_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int CW   = CW_DEF,
  parameter  int TW   = TW_DEF,
  localparam int OW   = owner_w(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*CW-1:0] req_maxcount_i,
  input  logic [NREQ*TW-1:0] req_ticks_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic              sclk_o,
  output logic              busy_o,
  output logic [OW-1:0]     owner_o
);

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   mc_q, mc_d;
  logic [TW-1:0]   tk_q, tk_d;
  logic [CW-1:0]   presc_q, presc_d;
  logic [TW:0]     half_q, half_d;
  logic            sclk_q, sclk_d;

  logic [NREQ-1:0] arb_gnt;
  logic [OW-1:0]   arb_idx;
  logic            arb_vld;
  logic [CW-1:0]   sel_mc;
  logic [TW-1:0]   sel_tk;

  logic [NREQ-1:0] owner_oh;
  logic [OW-1:0]   ptr_nxt;
  logic            owner_req;
  logic            zero_cfg;
  logic [CW-1:0]   presc_inc;
  logic            presc_wrap;
  logic [TW:0]     half_inc;
  logic            last_half;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign arb_vld = |arb_gnt;

  always_comb begin
    sel_mc = '0;
    sel_tk = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_mc = sel_mc | req_maxcount_i[i*CW +: CW];
        sel_tk = sel_tk | req_ticks_i[i*TW +: TW];
      end
    end
  end

  assign owner_oh   = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  assign ptr_nxt    = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_req  = req_i[owner_q];
  assign zero_cfg   = (mc_q == '0) || (tk_q == '0);
  assign presc_inc  = presc_q + 1'b1;
  assign presc_wrap = (presc_inc == mc_q);
  assign half_inc   = half_q + 1'b1;
  // The final toggle of the burst brings sclk back to 0, so no extra clear is needed.
  assign last_half  = presc_wrap && (half_inc == {tk_q, 1'b0});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_vld) state_d = RUN;
      RUN: begin
        if (!owner_req)                 state_d = IDLE;
        else if (zero_cfg || last_half) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    busy_o = 1'b0;
    case (state_q)
      RUN: begin
        gnt_o  = owner_oh;
        busy_o = 1'b1;
      end
      DONE: begin
        done_o = owner_oh;
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    ptr_d   = ptr_q;
    mc_d    = mc_q;
    tk_d    = tk_q;
    presc_d = presc_q;
    half_d  = half_q;
    sclk_d  = sclk_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          owner_d = arb_idx;
          mc_d    = sel_mc;
          tk_d    = sel_tk;
          presc_d = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
        end
      end
      RUN: begin
        if (!owner_req) begin
          presc_d = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
          ptr_d   = ptr_nxt;
        end else if (!zero_cfg) begin
          if (presc_wrap) begin
            presc_d = '0;
            half_d  = half_inc;
            sclk_d  = ~sclk_q;
          end else begin
            presc_d = presc_inc;
          end
        end
      end
      DONE: begin
        ptr_d   = ptr_nxt;
        presc_d = '0;
        half_d  = '0;
        sclk_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= '0;
      ptr_q   <= '0;
      mc_q    <= '0;
      tk_q    <= '0;
      presc_q <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      mc_q    <= mc_d;
      tk_q    <= tk_d;
      presc_q <= presc_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
    end
  end

  assign sclk_o  = sclk_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_shared_delay_scheduler.sv
// Scenario bench for shared_delay_scheduler against a burst-level reference model.
module tb_shared_delay_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 16;
  localparam int TW   = 8;
  localparam int OW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] req_mc;
  logic [NREQ*TW-1:0] req_tk;
  logic [NREQ-1:0]   gnt, done;
  logic              sclk, busy;
  logic [OW-1:0]     owner;

  int   errors = 0;
  int   checks = 0;
  int   model_ptr = 0;
  logic sclk_tr[$];

  always #5 clk = ~clk;

  shared_delay_scheduler #(.NREQ(NREQ), .CW(CW), .TW(TW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_maxcount_i (req_mc),
    .req_ticks_i    (req_tk),
    .gnt_o          (gnt),
    .done_o         (done),
    .sclk_o         (sclk),
    .busy_o         (busy),
    .owner_o        (owner)
  );

  // Reference model: burst length, divided-clock waveform and round-robin choice.
  function automatic int exp_run_len(input int mc, input int tk);
    if (mc == 0 || tk == 0) return 1;
    return 2 * mc * tk;
  endfunction

  function automatic logic exp_sclk(input int mc, input int k);
    if (mc == 0) return 1'b0;
    return ((k / mc) % 2) == 1;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int ptr);
    for (int i = 0; i < NREQ; i++)
      if (m[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return -1;
  endfunction

  function automatic int oh_index(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++)
      if (v[i] === 1'b1) begin
        if (r != -1) return -2;
        r = i;
      end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int i, input int mc, input int tk);
    req_mc[i*CW +: CW] = CW'(mc);
    req_tk[i*TW +: TW] = TW'(tk);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // Observer only: waits for a grant, records the sclk trace until gnt falls.
  task automatic follow_grant(input int budget, input bit scramble,
                              output int lat, output int who, output int run_len,
                              output logic [NREQ-1:0] done_v, output logic sclk_end);
    lat = -1; who = -1; run_len = 0; done_v = 'x; sclk_end = 1'bx;
    sclk_tr.delete();
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (gnt !== '0) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) return;
    who = oh_index(gnt);
    while (gnt !== '0 && run_len < budget) begin
      sclk_tr.push_back(sclk);
      run_len++;
      if (scramble) begin
        req_mc = {$urandom(), $urandom()};
        req_tk = $urandom();
      end
      tick();
    end
    done_v   = done;
    sclk_end = sclk;
  endtask

  task automatic test_reset();
    req = '0; req_mc = '0; req_tk = '0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (gnt !== '0)  begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== '0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    rst_n = 1'b1;
    model_ptr = 0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int lat, who, rl, bad;
    logic [NREQ-1:0] dv;
    logic se;
    set_cfg(0, 3, 2);
    req = 4'b0001;
    follow_grant(40, 1'b0, lat, who, rl, dv, se);
    bad = 0;
    foreach (sclk_tr[k]) if (sclk_tr[k] !== exp_sclk(3, k)) bad++;
    checks++; if (lat !== 1)  begin errors++; $display("FAIL single_lat: got %0d want 1", lat); end
    checks++; if (who !== 0)  begin errors++; $display("FAIL single_owner: got %0d want 0", who); end
    checks++; if (rl !== 12)  begin errors++; $display("FAIL single_runlen: got %0d want 12", rl); end
    checks++; if (bad !== 0)  begin errors++; $display("FAIL single_sclk: %0d wrong samples want 0", bad); end
    checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", dv); end
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL single_sclk_end: got %b want 0", se); end
    req = '0;
    model_ptr = 1;
    tick();
    checks++; if (done !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_contention();
    int lat, who, rl;
    logic [NREQ-1:0] dv;
    logic se;
    do_reset();
    set_cfg(0, 1, 1);
    set_cfg(2, 1, 1);
    req = 4'b0101;
    follow_grant(20, 1'b0, lat, who, rl, dv, se);
    checks++; if (who !== 0 || lat !== 1) begin errors++; $display("FAIL cont_first: owner=%0d lat=%0d want 0/1", who, lat); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL cont_owner0: got %0d want 0", owner); end
    checks++; if (rl !== 2 || dv !== 4'b0001) begin errors++; $display("FAIL cont_burst0: len=%0d done=%b want 2/0001", rl, dv); end
    req[0] = 1'b0;
    follow_grant(20, 1'b0, lat, who, rl, dv, se);
    checks++; if (who !== 2) begin errors++; $display("FAIL cont_second: got %0d want 2", who); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL cont_gap: got %0d want 2", lat); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL cont_owner2: got %0d want 2", owner); end
    checks++; if (dv !== 4'b0100) begin errors++; $display("FAIL cont_done2: got %b want 0100", dv); end
    req = '0;
    model_ptr = 3;
    tick();
  endtask

  task automatic test_fairness();
    int lat, who, rl;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] dv;
    logic se;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cfg(i, 2, 1);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      follow_grant(30, 1'b0, lat, who, rl, dv, se);
      checks++; if (who !== order[n] || lat !== (n == 0 ? 1 : 2) || rl !== 4) begin
        errors++; $display("FAIL fair_grant%0d: owner=%0d lat=%0d len=%0d want %0d/%0d/4",
                           n, who, lat, rl, order[n], (n == 0 ? 1 : 2));
      end
    end
    req = '0;
    model_ptr = 1;
    tick();
  endtask

  task automatic test_zero();
    int lat, who, rl;
    int zmc[2] = '{0, 4};
    int ztk[2] = '{5, 0};
    logic [NREQ-1:0] dv;
    logic se;
    for (int n = 0; n < 2; n++) begin
      set_cfg(1, zmc[n], ztk[n]);
      req = 4'b0010;
      follow_grant(20, 1'b0, lat, who, rl, dv, se);
      checks++; if (who !== 1 || rl !== 1) begin errors++; $display("FAIL zero%0d_run: owner=%0d len=%0d want 1/1", n, who, rl); end
      checks++; if (lat + rl !== 2 || dv !== 4'b0010) begin
        errors++; $display("FAIL zero%0d_done: delay=%0d done=%b want 2/0010", n, lat + rl, dv);
      end
      checks++; if (sclk_tr.size() != 1 || sclk_tr[0] !== 1'b0 || se !== 1'b0) begin
        errors++; $display("FAIL zero%0d_sclk: end=%b want 0 throughout", n, se);
      end
      req = '0;
      model_ptr = 2;
      tick();
    end
  endtask

  task automatic test_abort();
    int lat, who, rl, bad;
    logic [NREQ-1:0] dv;
    logic se;
    lat = -1;
    set_cfg(3, 4, 3);
    req = 4'b1000;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (gnt !== '0) begin lat = c; break; end
    end
    checks++; if (lat !== 1 || gnt !== 4'b1000) begin errors++; $display("FAIL abort_grant: lat=%0d gnt=%b want 1/1000", lat, gnt); end
    for (int c = 0; c < 6; c++) tick();
    checks++; if (sclk !== exp_sclk(4, 6)) begin errors++; $display("FAIL abort_pre_sclk: got %b want %b", sclk, exp_sclk(4, 6)); end
    set_cfg(0, 2, 2);
    req = 4'b0001;
    tick();
    checks++; if (sclk !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_stop: sclk=%b gnt=%b busy=%b want 0", sclk, gnt, busy);
    end
    checks++; if (done !== '0) begin errors++; $display("FAIL abort_nodone: got %b want 0", done); end
    follow_grant(40, 1'b0, lat, who, rl, dv, se);
    bad = 0;
    foreach (sclk_tr[k]) if (sclk_tr[k] !== exp_sclk(2, k)) bad++;
    checks++; if (who !== 0 || lat !== 1 || rl !== 8 || bad !== 0) begin
      errors++; $display("FAIL abort_next: owner=%0d lat=%0d len=%0d bad=%0d want 0/1/8/0", who, lat, rl, bad);
    end
    checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL abort_next_done: got %b want 0001", dv); end
    req = '0;
    model_ptr = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, who, rl;
    logic [NREQ-1:0] dv;
    logic se;
    lat = -1;
    set_cfg(2, 5, 4);
    req = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (gnt !== '0) begin lat = c; break; end
    end
    checks++; if (lat !== 1 || owner !== 2'd2) begin errors++; $display("FAIL rmid_grant: lat=%0d owner=%0d want 1/2", lat, owner); end
    for (int c = 0; c < 6; c++) tick();
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rmid_pre_sclk: got %b want 1", sclk); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sclk !== 1'b0 || gnt !== '0 || busy !== 1'b0 || owner !== '0 || done !== '0) begin
      errors++; $display("FAIL rmid_async: sclk=%b gnt=%b busy=%b owner=%0d done=%b want all 0",
                         sclk, gnt, busy, owner, done);
    end
    set_cfg(1, 1, 1);
    set_cfg(3, 1, 1);
    req = 4'b1110;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    follow_grant(20, 1'b0, lat, who, rl, dv, se);
    checks++; if (who !== rr_pick(4'b1110, 0) || lat !== 1) begin
      errors++; $display("FAIL rmid_rearb: owner=%0d lat=%0d want %0d/1", who, lat, rr_pick(4'b1110, 0));
    end
    req = '0;
    model_ptr = 2;
    tick();
  endtask

  task automatic test_random();
    int lat, who, rl, bad, exp_who;
    int mcs[NREQ];
    int tks[NREQ];
    logic [NREQ-1:0] mask, dv, exp_done;
    logic se;
    for (int n = 0; n < 24; n++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        mcs[i] = $urandom_range(0, 4);
        tks[i] = $urandom_range(0, 3);
        set_cfg(i, mcs[i], tks[i]);
      end
      exp_who  = rr_pick(mask, model_ptr);
      exp_done = NREQ'(1) << exp_who;
      req = mask;
      follow_grant(200, 1'b1, lat, who, rl, dv, se);
      bad = 0;
      foreach (sclk_tr[k]) if (sclk_tr[k] !== exp_sclk(mcs[exp_who], k)) bad++;
      checks++; if (who !== exp_who || lat !== 1) begin
        errors++; $display("FAIL rand%0d_owner: owner=%0d lat=%0d want %0d/1", n, who, lat, exp_who);
      end
      checks++; if (rl !== exp_run_len(mcs[exp_who], tks[exp_who]) || bad !== 0) begin
        errors++; $display("FAIL rand%0d_burst: len=%0d bad=%0d want %0d/0", n, rl, bad,
                           exp_run_len(mcs[exp_who], tks[exp_who]));
      end
      checks++; if (dv !== exp_done || se !== 1'b0) begin
        errors++; $display("FAIL rand%0d_done: done=%b sclk=%b want %b/0", n, dv, se, exp_done);
      end
      req = '0;
      model_ptr = (exp_who + 1) % NREQ;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_zero();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
